// File: rtl/psum_acc_spad.sv
// Accumulating partial-sum scratchpad: read-add-write pipeline with same-entry forwarding,
// a clear sequencer and a write-first read port. Build macro PSUM_SAT_EN selects saturating adds.
module psum_acc_spad #(
   parameter int MEM_DEPTH  = 24,
   parameter int DATA_WIDTH = 16,
   parameter int IN_WIDTH   = 16,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  acc_valid_i,
   output logic                  acc_ready_o,
   input  logic [ADDR_WIDTH-1:0] acc_addr_i,
   input  logic [IN_WIDTH-1:0]   acc_data_i,
   input  logic                  acc_init_i,
   input  logic                  clr_start_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  ovf_flag_o
);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
`ifdef PSUM_SAT_EN
   localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic                    clr_we;

   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

   logic [DATA_WIDTH-1:0]   acc_ext;
   logic                    acc_fire;
   logic [DATA_WIDTH-1:0]   opnd_d;

   logic                    s2_vld_q;
   logic [ADDR_WIDTH-1:0]   s2_addr_q;
   logic [DATA_WIDTH-1:0]   s2_data_q;
   logic                    s2_init_q;
   logic [DATA_WIDTH-1:0]   s2_opnd_q;

   logic [DATA_WIDTH:0]     sum_w;
   logic                    ovf_w;
   logic [DATA_WIDTH-1:0]   result;

   logic                    ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                    rd_valid_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= CLEAR;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_cnt_q == LAST_ADDR) state_d = RUN;
         RUN:     if (clr_start_i) state_d = DRAIN;
         DRAIN:   state_d = CLEAR;
         default: state_d = CLEAR;
      endcase
   end

   always_comb begin
      acc_ready_o = (state_q == RUN);
      clr_we      = (state_q == CLEAR);
   end

   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if (clr_we) clr_cnt_d = (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDR_WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) clr_cnt_q <= '0;
      else         clr_cnt_q <= clr_cnt_d;
   end

   // ---------------- stage 1: accept and operand fetch ----------------
   generate
      if (IN_WIDTH < DATA_WIDTH) begin : g_sext
         assign acc_ext = {{(DATA_WIDTH-IN_WIDTH){acc_data_i[IN_WIDTH-1]}}, acc_data_i};
      end else begin : g_nosext
         assign acc_ext = acc_data_i[DATA_WIDTH-1:0];
      end
   endgenerate

   assign acc_fire = acc_valid_i && acc_ready_o;

   // An in-flight result for the same entry has not reached the array yet.
   always_comb begin
      opnd_d = mem_q[acc_addr_i];
      if (s2_vld_q && (s2_addr_q == acc_addr_i)) opnd_d = result;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s2_vld_q  <= 1'b0;
         s2_addr_q <= '0;
         s2_data_q <= '0;
         s2_init_q <= 1'b0;
         s2_opnd_q <= '0;
      end else begin
         s2_vld_q <= acc_fire;
         if (acc_fire) begin
            s2_addr_q <= acc_addr_i;
            s2_data_q <= acc_ext;
            s2_init_q <= acc_init_i;
            s2_opnd_q <= opnd_d;
         end
      end
   end

   // ---------------- stage 2: add and commit ----------------
   always_comb begin
      sum_w  = {s2_opnd_q[DATA_WIDTH-1], s2_opnd_q} + {s2_data_q[DATA_WIDTH-1], s2_data_q};
      // Top two sum bits disagree exactly when equal-signed operands produce a flipped sign.
      ovf_w  = ~s2_init_q & (sum_w[DATA_WIDTH] ^ sum_w[DATA_WIDTH-1]);
      result = sum_w[DATA_WIDTH-1:0];
`ifdef PSUM_SAT_EN
      if (ovf_w) result = s2_opnd_q[DATA_WIDTH-1] ? MIN_VAL : MAX_VAL;
`endif
      if (s2_init_q) result = s2_data_q;
   end

   always_ff @(posedge clk_i) begin
      if (s2_vld_q)    mem_q[s2_addr_q] <= result;
      else if (clr_we) mem_q[clr_cnt_q] <= '0;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (state_q != CLEAR && state_d == CLEAR) ovf_d = 1'b0;
      else if (s2_vld_q && ovf_w)               ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ovf_q <= 1'b0;
      else         ovf_q <= ovf_d;
   end

   // ---------------- read port ----------------
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         if (s2_vld_q && (s2_addr_q == rd_addr_i)) rd_data_d = result;
         else                                      rd_data_d = mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_en_i;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign ovf_flag_o = ovf_q;

endmodule
